register_file_mp: RTL



---
 rtl/register_file_mp.sv | 99 +++++++++
 1 files changed

// File: rtl/register_file_mp.sv
// Multi-ported register file: two write ports, two combinational read ports,
// optional same-cycle write-to-read bypass and a post-reset clear sweep.
module register_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] ra,
  input  logic [ADDR_WIDTH-1:0] rb,
  output logic [DATA_WIDTH-1:0] bus_a,
  output logic [DATA_WIDTH-1:0] bus_b,
  input  logic [ADDR_WIDTH-1:0] rw0,
  input  logic                  we0,
  input  logic [DATA_WIDTH-1:0] bus_w0,
  input  logic [ADDR_WIDTH-1:0] rw1,
  input  logic                  we1,
  input  logic [DATA_WIDTH-1:0] bus_w1,
  output logic                  ready
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = {ADDR_WIDTH{1'b1}};

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] clr_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic wr0_ok;
  logic wr1_ok;

  // Register 0 swallows writes when it is hard-wired to zero.
  assign wr0_ok = we0 && !(ZERO_REG != 0 && rw0 == '0);
  assign wr1_ok = we1 && !(ZERO_REG != 0 && rw1 == '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      ready   <= 1'b0;
    end else if (state == CLEAR) begin
      clr_ptr <= clr_ptr + 1'b1;
      if (clr_ptr == LAST_IDX) begin
        state <= RUN;
        ready <= 1'b1;
      end
    end
  end

  // NOTE: the array has no reset branch; the clear sweep zeroes it one entry
  // per cycle, which keeps it mappable onto plain RAM/flop arrays.
  always_ff @(posedge clock) begin
    if (reset_n) begin
      if (state == CLEAR) begin
        mem[clr_ptr] <= '0;
      end else begin
        // Port 1 is written last so it wins an address collision.
        if (wr0_ok) mem[rw0] <= bus_w0;
        if (wr1_ok) mem[rw1] <= bus_w1;
      end
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_mux(
    input logic                  rdy,
    input logic [ADDR_WIDTH-1:0] idx,
    input logic [DATA_WIDTH-1:0] stored,
    input logic                  w0_en,
    input logic [ADDR_WIDTH-1:0] w0_idx,
    input logic [DATA_WIDTH-1:0] w0_data,
    input logic                  w1_en,
    input logic [ADDR_WIDTH-1:0] w1_idx,
    input logic [DATA_WIDTH-1:0] w1_data
  );
    logic [DATA_WIDTH-1:0] res;
    res = stored;
    if (!rdy) begin
      res = '0;
    end else if (ZERO_REG != 0 && idx == '0) begin
      res = '0;
    end else if (BYPASS != 0 && w1_en && w1_idx == idx) begin
      res = w1_data;
    end else if (BYPASS != 0 && w0_en && w0_idx == idx) begin
      res = w0_data;
    end
    return res;
  endfunction

  assign bus_a = read_mux(ready, ra, mem[ra], we0, rw0, bus_w0, we1, rw1, bus_w1);
  assign bus_b = read_mux(ready, rb, mem[rb], we0, rw0, bus_w0, we1, rw1, bus_w1);

endmodule
